// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared one
// DIGIT-bit slice per clock, most-significant slice first. The scan stops at
// the first slice that differs. Signed (two's-complement) operands are handled
// by flipping the sign bit of both operands at capture. After that flip, an
// unsigned compare gives the signed ordering.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; results hold the last completed comparison
//   SCAN  | comparing slice idx_q of the captured operands, one slice per clock
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a comparison (accepted only while busy=0)
//   a, b         operands, sampled on the accepting edge
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   busy         high while a scan is in progress
//   done         one-cycle pulse; results update on the same edge
//   greater      A > B for the last completed comparison
//   equal        A == B for the last completed comparison
//   less         A < B for the last completed comparison

module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             equal,
    output logic             less
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]    TOP_IDX  = IW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic [DIGIT-1:0] slice_a, slice_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        slice_a = a_q[idx_q*DIGIT +: DIGIT];
        slice_b = b_q[idx_q*DIGIT +: DIGIT];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d     = signed_mode ? (a ^ MSB_MASK) : a;
                    b_d     = signed_mode ? (b ^ MSB_MASK) : b;
                    idx_d   = TOP_IDX;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (slice_a > slice_b) begin
                    gt_d    = 1'b1;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (slice_a < slice_b) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == SCAN);
    assign done    = done_q;
    assign greater = gt_q;
    assign equal   = eq_q;
    assign less    = lt_q;

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised multi-cycle magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, most-significant slice first, and stops as soon as a slice differs. It supports unsigned and two's-complement modes and uses a start/busy/done handshake. It is the sequential, width-generic successor to the team's fixed 16-bit slice comparator, for datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 16: operand width in bits; must be an integer multiple of DIGIT, ≥ DIGIT.
- DIGIT, 4: slice width compared per cycle; NDIG = WIDTH/DIGIT.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request a comparison; accepted only when busy=0.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse; results are updated on the same edge.
- greater  output  1  A > B for the last completed comparison.
- equal  output  1  A == B for the last completed comparison.
- less  output  1  A < B for the last completed comparison.

## Operation
- State machine: IDLE, SCAN.
- Reset (rst_n=0 at an edge): state IDLE. busy, done, greater, equal and less are all 0. Internal operand registers and slice index are cleared. Reset takes priority over every other event, including a scan in progress; the aborted scan produces no done.
- IDLE, start=1:
  - Capture a, b and signed_mode.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands. This gives two's-complement ordering under an unsigned compare.
  - Set index=NDIG-1, busy=1, go to SCAN.
- IDLE, start=0: hold. done=0.
- SCAN, each edge: compare slice [index*DIGIT +: DIGIT] of A and B as unsigned values.
  - Slice A > slice B: greater=1, equal=0, less=0, done=1, busy=0, go to IDLE.
  - Slice A < slice B: less=1, greater=0, equal=0, done=1, busy=0, go to IDLE.
  - Equal and index=0: equal=1, greater=0, less=0, done=1, busy=0, go to IDLE.
  - Equal and index>0: index decrements, stay in SCAN.
- start is ignored while busy=1; no queuing.
- Exactly one of greater/equal/less is 1 after the first done. All three are 0 only before the first done after reset.
- Result outputs change only on a done edge and hold otherwise, including throughout a subsequent scan.
- Degenerate case NDIG=1: every comparison completes in one cycle.

## Timing
- Accept edge E0: start=1 with busy=0. busy reads 1 from E0 until the done edge.
- Latency: done rises at edge E0+k, where k = 1 + (number of leading equal slices), capped at NDIG. Range is 1..NDIG cycles. Operands differing in the top slice finish at E0+1; equal operands finish at E0+NDIG.
- done is high for exactly one cycle. busy falls on the same edge that done rises.
- Back-to-back operation: start=1 in the cycle done=1 is accepted at the next edge, because state is IDLE. Sustained throughput is one comparison per k+1 cycles.
- Changes to a, b or signed_mode after E0 have no effect on the comparison in flight.
- rst_n low during SCAN: busy=0 and results=0 at that edge. No done pulse follows.

## Test plan
- WIDTH=16, DIGIT=4, unsigned: a=0x1234, b=0x1234, start at E0 -> done at E0+4; equal=1, greater=0, less=0.
- Unsigned: a=0x8000, b=0x7FFF -> done at E0+1, greater=1. Same operands with signed_mode=1 -> done at E0+1, less=1.
- Early exit and last-slice decision: a=0x1300, b=0x1234 -> done at E0+2, greater=1. a=0x1234, b=0x1235 -> done at E0+4, less=1.
- Signed negatives: a=0xFFFF (-1), b=0xFFFE (-2), signed_mode=1 -> greater=1 at E0+4. a=0x8000, b=0x8000 -> equal=1 at E0+4.
- Handshake: start held high continuously and operands changed mid-scan -> only the captured pair is compared. busy stays 1 until done, and the next accept occurs on the edge after done. Results hold stable between done pulses.
- Reset mid-scan: a=0x1234, b=0x1234, rst_n=0 at E0+2 -> busy=0 and all results 0 at that edge, no done. A new start after release completes normally.
